// File: rtl/lsu_mem_if.sv
// Bundle of the execute-side request/response and the dcache request/response signals.
// The load/store unit uses the slave view; the execute stage and the dcache use the master view.
interface lsu_mem_if;
    logic        lsu_start;
    logic        lsu_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_base;
    logic [11:0] lsu_offset;
    logic [31:0] lsu_storedata;
    logic [4:0]  lsu_rd;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_result;
    logic [4:0]  lsu_rd_out;
    logic        lsu_we;
    logic        lsu_fault;
    logic [31:0] dcache_addr;
    logic        dcache_rdreq;
    logic        dcache_wrreq;
    logic [31:0] dcache_datain;
    logic [1:0]  dcache_bytenum;
    logic [31:0] dcache_dataout;
    logic        dcache_valid;

    modport slave (
        input  lsu_start, lsu_store, lsu_funct3, lsu_base, lsu_offset,
               lsu_storedata, lsu_rd, dcache_dataout, dcache_valid,
        output lsu_busy, lsu_done, lsu_result, lsu_rd_out, lsu_we, lsu_fault,
               dcache_addr, dcache_rdreq, dcache_wrreq, dcache_datain, dcache_bytenum
    );

    modport master (
        output lsu_start, lsu_store, lsu_funct3, lsu_base, lsu_offset,
               lsu_storedata, lsu_rd, dcache_dataout, dcache_valid,
        input  lsu_busy, lsu_done, lsu_result, lsu_rd_out, lsu_we, lsu_fault,
               dcache_addr, dcache_rdreq, dcache_wrreq, dcache_datain, dcache_bytenum
    );
endinterface

// File: rtl/lsu_mem.sv
// Single-outstanding RV32I load/store unit in front of the data cache.
// All outputs are registered; the dcache request drops asynchronously on reset.
//
// state  | meaning
// IDLE   | waiting for lsu_start; request and timer idle
// REQ    | first request cycle, dcache_valid ignored (may be stale)
// WAIT   | request held until dcache_valid or time-out
// DONE   | one-cycle completion pulse, then back to IDLE
module lsu_mem #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     reset_n,
    lsu_mem_if.slave lsu_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [1:0]  r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;

    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;
    logic        r_we;
    logic        r_fault;
    logic [31:0] r_addr;
    logic        r_rdreq;
    logic        r_wrreq;
    logic [31:0] r_datain;
    logic [1:0]  r_bytenum;

    logic        w_illegal;
    logic [31:0] w_eff_addr;
    logic [1:0]  w_bytenum;
    logic [31:0] w_ext;
    logic [15:0] w_cnt_inc;

    always_comb begin
        w_illegal = 1'b0;
        if (lsu_bus.lsu_store) begin
            w_illegal = (lsu_bus.lsu_funct3 > 3'd2);
        end else begin
            w_illegal = (lsu_bus.lsu_funct3 == 3'd3) || (lsu_bus.lsu_funct3 == 3'd6) ||
                        (lsu_bus.lsu_funct3 == 3'd7);
        end
    end

    assign w_eff_addr = lsu_bus.lsu_base + {{20{lsu_bus.lsu_offset[11]}}, lsu_bus.lsu_offset};

    // funct3[1:0] 0/1/2 maps to byte count minus one 0/1/3
    assign w_bytenum  = {lsu_bus.lsu_funct3[1], lsu_bus.lsu_funct3[1] | lsu_bus.lsu_funct3[0]};

    assign w_cnt_inc  = r_cnt + 16'd1;

    always_comb begin
        w_ext = lsu_bus.dcache_dataout;
        case (r_funct3)
            3'd0:    w_ext = {{24{lsu_bus.dcache_dataout[7]}}, lsu_bus.dcache_dataout[7:0]};
            3'd1:    w_ext = {{16{lsu_bus.dcache_dataout[15]}}, lsu_bus.dcache_dataout[15:0]};
            3'd4:    w_ext = {24'd0, lsu_bus.dcache_dataout[7:0]};
            3'd5:    w_ext = {16'd0, lsu_bus.dcache_dataout[15:0]};
            default: w_ext = lsu_bus.dcache_dataout;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_store   <= 1'b0;
            r_funct3  <= 3'd0;
            r_rd      <= 5'd0;
            r_cnt     <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= 32'd0;
            r_rd_out  <= 5'd0;
            r_we      <= 1'b0;
            r_fault   <= 1'b0;
            r_addr    <= 32'd0;
            r_rdreq   <= 1'b0;
            r_wrreq   <= 1'b0;
            r_datain  <= 32'd0;
            r_bytenum <= 2'd0;
        end else begin
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_bus.lsu_start) begin
                        r_store  <= lsu_bus.lsu_store;
                        r_funct3 <= lsu_bus.lsu_funct3;
                        r_rd     <= lsu_bus.lsu_rd;
                        r_datain <= lsu_bus.lsu_storedata;
                        r_addr   <= w_eff_addr;
                        r_busy   <= 1'b1;
                        if (w_illegal) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_fault  <= 1'b1;
                            r_rd_out <= lsu_bus.lsu_rd;
                        end else begin
                            r_state   <= S_REQ;
                            r_rdreq   <= !lsu_bus.lsu_store;
                            r_wrreq   <= lsu_bus.lsu_store;
                            r_bytenum <= w_bytenum;
                        end
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (lsu_bus.dcache_valid) begin
                        r_state  <= S_DONE;
                        r_rdreq  <= 1'b0;
                        r_wrreq  <= 1'b0;
                        r_done   <= 1'b1;
                        r_rd_out <= r_rd;
                        r_we     <= !r_store && (r_rd != 5'd0);
                        if (!r_store) begin
                            r_result <= w_ext;
                        end
                    end else if (w_cnt_inc == TIMEOUT_CNT) begin
                        r_state  <= S_DONE;
                        r_rdreq  <= 1'b0;
                        r_wrreq  <= 1'b0;
                        r_done   <= 1'b1;
                        r_fault  <= 1'b1;
                        r_rd_out <= r_rd;
                        r_result <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign lsu_bus.lsu_busy       = r_busy;
    assign lsu_bus.lsu_done       = r_done;
    assign lsu_bus.lsu_result     = r_result;
    assign lsu_bus.lsu_rd_out     = r_rd_out;
    assign lsu_bus.lsu_we         = r_we;
    assign lsu_bus.lsu_fault      = r_fault;
    assign lsu_bus.dcache_addr    = r_addr;
    assign lsu_bus.dcache_rdreq   = r_rdreq;
    assign lsu_bus.dcache_wrreq   = r_wrreq;
    assign lsu_bus.dcache_datain  = r_datain;
    assign lsu_bus.dcache_bytenum = r_bytenum;
endmodule

// File: doc/lsu_mem.md
# lsu_mem

Load/store unit sitting directly upstream of the data cache. Accepts one RV32I load or store per request from the execute stage and computes the effective address. Drives the dcache request interface, then sign/zero-extends returned load data and hands it to register writeback. Handles only one access at a time; flags illegal widths and dcache time-outs as faults.

## Interface
- TIMEOUT, 1024: WAIT cycles without dcache_valid before a time-out fault (1..65535).
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- lsu_start  in  1  request strobe from execute; sampled only in IDLE.
- lsu_store  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RV32I funct3: loads 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; stores 0=SB, 1=SH, 2=SW.
- lsu_base  in  32  rs1 value.
- lsu_offset  in  12  signed immediate.
- lsu_storedata  in  32  rs2 value; bytes used from bit 0 upward.
- lsu_rd  in  5  destination register.
- lsu_busy  out  1  high whenever state != IDLE.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_result  out  32  extended load data; held until next done.
- lsu_rd_out  out  5  rd of the completed access.
- lsu_we  out  1  writeback enable, coincident with lsu_done.
- lsu_fault  out  1  fault flag, coincident with lsu_done.
- dcache_addr  out  32  byte address; any alignment.
- dcache_rdreq  out  1  read request level.
- dcache_wrreq  out  1  write request level.
- dcache_datain  out  32  store data.
- dcache_bytenum  out  2  access bytes minus one: 0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes.
- dcache_dataout  in  32  read data; byte at dcache_addr appears on [7:0].
- dcache_valid  in  1  cache ready/data valid (level).

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- Reset: state IDLE; every output 0, including lsu_result and dcache_addr; timeout counter 0.
- IDLE with lsu_start=1:
  - Latch lsu_store, lsu_funct3, lsu_rd and lsu_storedata.
  - dcache_addr <= lsu_base + sign_extend(lsu_offset), modulo 2^32. 0xFFFFFFFF + 1 wraps to 0.
  - Legal request -> REQ. Illegal funct3 -> DONE with fault=1 and no dcache request issued.
  - Illegal funct3: loads 3, 6, 7; stores 3..7.
- REQ (exactly 1 cycle):
  - dcache_rdreq = !store, dcache_wrreq = store.
  - bytenum from funct3[1:0] (0 -> 0, 1 -> 1, 2 -> 3); dcache_datain = latched storedata.
  - dcache_valid is ignored in REQ because it can be stale high from the previous access. -> WAIT.
- WAIT:
  - Request, address, datain and bytenum are held stable; the counter increments each cycle.
  - dcache_valid=1: capture and extend the data, drop both requests, -> DONE.
  - Counter reaches TIMEOUT with no valid: drop requests, result=0, fault=1, -> DONE.
- Load extension:
  - LB: sext [7:0]. LBU: zext [7:0].
  - LH: sext [15:0]. LHU: zext [15:0].
  - LW: [31:0].
- DONE (1 cycle):
  - lsu_done=1; lsu_rd_out = latched rd.
  - lsu_we = load & !fault & (rd != 0).
  - Stores never write back; lsu_result is unchanged on stores and on illegal-funct3 faults.
  - -> IDLE; the counter clears.
- lsu_start outside IDLE, including the DONE cycle, is ignored and never queued.
- Reset asserted mid-access: immediate return to IDLE with all outputs 0. The dcache request drops asynchronously.

## Timing
- Start sampled at edge 0 -> REQ visible after edge 0 -> WAIT after edge 1.
- dcache_valid sampled high at edge 2 -> lsu_done high after edge 2.
- Minimum latency is 3 cycles from the start edge to the done pulse. Each extra WAIT cycle adds 1.
- Illegal funct3: done is visible after edge 0 (1 cycle).
- Time-out: done occurs TIMEOUT+2 cycles after start.
- Back-to-back: the next start is accepted at the edge following the DONE cycle. Peak throughput is 1 access per 4 cycles.

## Test plan
- Load LB, base=0x1000, offset=0xFFF (-1), dcache returns 0x000000F0 at the first WAIT edge -> dcache_addr=0x00000FFF, bytenum=0, done at cycle 3, result=0xFFFFFFF0, we=1.
- Load LHU, base=0xFFFFFFFE, offset=3, rd=0, data 0x1234ABCD -> addr=0x00000001 (wrap), result=0x0000ABCD, we=0 (rd=0), fault=0.
- Store SW, storedata=0xDEADBEEF, dcache_valid delayed 5 cycles -> wrreq held 6 cycles with stable addr/datain, bytenum=3, done with we=0, lsu_result unchanged.
- Load with funct3=3 -> no rdreq/wrreq ever asserted, done after 1 cycle with fault=1, we=0.
- TIMEOUT=8, dcache_valid tied 0 -> rdreq high 9 cycles, done with fault=1, result=0; lsu_start pulsed during WAIT is ignored.
- reset_n pulsed low in WAIT -> rdreq, busy and done are 0 immediately. After release, a new LW completes normally.
